// File: rtl/mem_pkg.sv
// Shared constants, access-mode encodings and FSM state type for the memory arbiter.
package mem_pkg;

    localparam int RAM_SIZE_LOG = 8;

    localparam logic [2:0] BYTE        = 3'b000;
    localparam logic [2:0] HALF_WORD   = 3'b001;
    localparam logic [2:0] WORD        = 3'b010;
    localparam logic [2:0] U_BYTE      = 3'b100;
    localparam logic [2:0] U_HALF_WORD = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Unsigned modes only make sense on the read path.
    function automatic logic legal_write_mode(input logic [2:0] mode);
        return (mode == BYTE) || (mode == HALF_WORD) || (mode == WORD);
    endfunction

    function automatic logic legal_read_mode(input logic [2:0] mode);
        return (mode == BYTE) || (mode == HALF_WORD) || (mode == WORD) ||
               (mode == U_BYTE) || (mode == U_HALF_WORD);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: i_ptr names the requester that wins
// first, priority then increases in index order with wrap-around.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [2*N_REQ-1:0] w_gnt_dbl;
    logic [N_REQ-1:0]   w_rot_req;
    logic [N_REQ-1:0]   w_rot_gnt;

    // Rotate so the pointer lands on bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        w_req_dbl = {i_req, i_req} >> i_ptr;
        w_rot_req = w_req_dbl[N_REQ-1:0];
        w_rot_gnt = w_rot_req & (-w_rot_req);
        w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << i_ptr;
        o_gnt     = w_gnt_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for fetch (0) and load/store (1) requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise highest index wins.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_SIZE_LOG,
    parameter int N_REQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [N_REQ*3-1:0]    req_mode,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*32-1:0]   req_wdata,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_wa,
    output logic [2:0]            mem_wm,
    output logic [31:0]           mem_wd,
    output logic [ADDR_W-1:0]     mem_ra,
    output logic [2:0]            mem_rm,
    input  logic [31:0]           mem_rd
);

    localparam int GI_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              r_state;
    state_t              w_next_state;

    logic [GI_W-1:0]     r_gnt_idx;
    logic                r_we;
    logic [2:0]          r_mode;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic [N_REQ-1:0]    w_gnt;
    logic [GI_W-1:0]     w_gnt_idx;
    logic                w_sel_we;
    logic [2:0]          w_sel_mode;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_accept;
    logic                w_resp_ack;
    logic                w_in_access;
    logic                w_wr_legal;
    logic                w_rd_legal;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GI_W-1:0]     r_rr_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (GI_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt)
    );

    // After a grant, the requester just above the winner gets first claim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            if (w_gnt_idx == GI_W'(N_REQ - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= GI_W'(w_gnt_idx + 1'b1);
            end
        end
    end
`else
    logic [N_REQ-1:0]    w_req_rev;
    logic [N_REQ-1:0]    w_gnt_rev;

    // Reversing the request vector with a fixed pointer of 0 makes the top index win.
    always_comb begin
        w_req_rev = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_req_rev[k] = req_valid[N_REQ-1-k];
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (GI_W)
    ) u_arb (
        .i_req (w_req_rev),
        .i_ptr ('0),
        .o_gnt (w_gnt_rev)
    );

    always_comb begin
        w_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_gnt[k] = w_gnt_rev[N_REQ-1-k];
        end
    end
`endif

    always_comb begin
        w_gnt_idx   = '0;
        w_sel_we    = 1'b0;
        w_sel_mode  = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx   = GI_W'(k);
                w_sel_we    = req_we[k];
                w_sel_mode  = req_mode[k*3 +: 3];
                w_sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[k*32 +: 32];
            end
        end
    end

    assign w_in_access = (r_state == ACCESS);
    assign w_wr_legal  = legal_write_mode(r_mode);
    assign w_rd_legal  = legal_read_mode(r_mode);
    assign w_accept    = |(req_valid & req_ready);

    always_comb begin
        w_resp_ack = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gnt_idx == GI_W'(k)) begin
                w_resp_ack = resp_ready[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    if (w_resp_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_idx <= '0;
            r_we      <= 1'b0;
            r_mode    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_gnt_idx <= w_gnt_idx;
            r_we      <= w_sel_we;
            r_mode    <= w_sel_mode;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
        end else if (w_in_access) begin
            // Writes and illegal reads return zero; rdata/err then hold through RESP.
            r_rdata <= (!r_we && w_rd_legal) ? mem_rd : 32'h0;
            r_err   <= r_we ? !w_wr_legal : !w_rd_legal;
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        mem_we     = 1'b0;
        mem_wa     = '0;
        mem_wm     = '0;
        mem_wd     = '0;
        mem_ra     = '0;
        mem_rm     = '0;
        case (r_state)
            IDLE: begin
                req_ready = w_gnt & req_valid;
            end
            ACCESS: begin
                if (r_we) begin
                    mem_we = w_wr_legal;
                    mem_wa = r_addr;
                    mem_wm = r_mode;
                    mem_wd = r_wdata;
                end else begin
                    mem_ra = r_addr;
                    mem_rm = r_mode;
                end
            end
            RESP: begin
                for (int k = 0; k < N_REQ; k++) begin
                    resp_valid[k] = (r_gnt_idx == GI_W'(k));
                end
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
